// File: rtl/alu_pkg.sv
// Shared ALU sequencer definitions: opcodes, opcode legality check, FSM state type, default widths.
package alu_pkg;

   localparam int unsigned WIDTH_DEF = 32;
   localparam int unsigned OP_W_DEF  = 4;

   localparam logic [OP_W_DEF-1:0] ALU_ADD   = 4'b0000;
   localparam logic [OP_W_DEF-1:0] ALU_SLL   = 4'b0001;
   localparam logic [OP_W_DEF-1:0] ALU_SLT   = 4'b0010;
   localparam logic [OP_W_DEF-1:0] ALU_SLTU  = 4'b0011;
   localparam logic [OP_W_DEF-1:0] ALU_XOR   = 4'b0100;
   localparam logic [OP_W_DEF-1:0] ALU_SRL   = 4'b0101;
   localparam logic [OP_W_DEF-1:0] ALU_OR    = 4'b0110;
   localparam logic [OP_W_DEF-1:0] ALU_AND   = 4'b0111;
   localparam logic [OP_W_DEF-1:0] ALU_SUB   = 4'b1000;
   localparam logic [OP_W_DEF-1:0] ALU_PASSB = 4'b1001;
   localparam logic [OP_W_DEF-1:0] ALU_SRA   = 4'b1101;

   typedef enum logic [1:0] {
      StIdle,
      StExec,
      StResp
   } state_e;

   function automatic logic is_legal_op(input logic [OP_W_DEF-1:0] op);
      case (op)
         ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR,
         ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_PASSB: return 1'b1;
         default:                                      return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/alu_share_arbiter_if.sv
// Requester-side request/response handshake bundle for alu_share_arbiter.
interface alu_share_arbiter_if #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned OP_W  = 4
);
   logic [1:0]       req_valid;
   logic [1:0]       req_ready;
   logic [OP_W-1:0]  req_op0;
   logic [WIDTH-1:0] req_a0;
   logic [WIDTH-1:0] req_b0;
   logic [OP_W-1:0]  req_op1;
   logic [WIDTH-1:0] req_a1;
   logic [WIDTH-1:0] req_b1;
   logic [1:0]       rsp_valid;
   logic [1:0]       rsp_ready;
   logic [WIDTH-1:0] rsp_data;
   logic             rsp_err;

   modport master (
      output req_valid, req_op0, req_a0, req_b0, req_op1, req_a1, req_b1, rsp_ready,
      input  req_ready, rsp_valid, rsp_data, rsp_err
   );

   modport slave (
      input  req_valid, req_op0, req_a0, req_b0, req_op1, req_a1, req_b1, rsp_ready,
      output req_ready, rsp_valid, rsp_data, rsp_err
   );
endinterface

// File: rtl/rr_arb2.sv
// Two-input arbiter; round-robin when ALU_ARB_RR_EN is defined, else fixed priority to input 0.
module rr_arb2 (
`ifdef ALU_ARB_RR_EN
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_advance,
`endif
   input  logic [1:0] i_req,
   output logic [1:0] o_gnt
);

`ifdef ALU_ARB_RR_EN
   logic r_prio;  // 1: requester 1 wins the next tie

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_prio <= 1'b0;
      end else if (i_advance) begin
         r_prio <= o_gnt[0];
      end
   end

   always_comb begin
      o_gnt = 2'b00;
      if (&i_req) begin
         o_gnt = r_prio ? 2'b10 : 2'b01;
      end else begin
         o_gnt = i_req;
      end
   end
`else
   always_comb begin
      o_gnt = 2'b00;
      if (i_req[0]) begin
         o_gnt = 2'b01;
      end else if (i_req[1]) begin
         o_gnt = 2'b10;
      end
   end
`endif

endmodule

// File: rtl/alu_share_arbiter.sv
// Time-shares one combinational ALU between two requesters (IDLE/EXEC/RESP sequencer).
// Build option: ALU_ARB_RR_EN selects round-robin arbitration instead of fixed R0 priority.
module alu_share_arbiter
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH = WIDTH_DEF,
   parameter int unsigned OP_W  = OP_W_DEF
) (
   input  logic                i_clk,
   input  logic                i_rst_n,
   alu_share_arbiter_if.slave  io_bus,
   output logic [WIDTH-1:0]    o_alu_a,
   output logic [WIDTH-1:0]    o_alu_b,
   output logic [OP_W-1:0]     o_alu_op,
   input  logic [WIDTH-1:0]    i_alu_res
);

   state_e           r_state, w_state_nxt;
   logic             r_owner;
   logic [OP_W-1:0]  r_op;
   logic [WIDTH-1:0] r_a, r_b, r_data;
   logic             r_err;

   logic [1:0]       w_gnt;
   logic             w_accept;
   logic             w_sel;
   logic [OP_W-1:0]  w_op_sel;
   logic [WIDTH-1:0] w_a_sel, w_b_sel;
   logic             w_legal;

   assign w_accept = (r_state == StIdle) && (|io_bus.req_valid);

   rr_arb2 u_arb (
`ifdef ALU_ARB_RR_EN
      .i_clk     (i_clk),
      .i_rst_n   (i_rst_n),
      .i_advance (w_accept),
`endif
      .i_req     (io_bus.req_valid),
      .o_gnt     (w_gnt)
   );

   assign w_sel    = w_gnt[1];
   assign w_op_sel = w_sel ? io_bus.req_op1 : io_bus.req_op0;
   assign w_a_sel  = w_sel ? io_bus.req_a1  : io_bus.req_a0;
   assign w_b_sel  = w_sel ? io_bus.req_b1  : io_bus.req_b0;
   assign w_legal  = is_legal_op(w_op_sel);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= StIdle;
         r_owner <= 1'b0;
         r_op    <= '0;
         r_a     <= '0;
         r_b     <= '0;
         r_err   <= 1'b0;
         r_data  <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_accept) begin
            // Illegal ops run as ADD 0+0 so the ALU sees quiet, defined inputs.
            r_owner <= w_sel;
            r_op    <= w_legal ? w_op_sel : '0;
            r_a     <= w_legal ? w_a_sel  : '0;
            r_b     <= w_legal ? w_b_sel  : '0;
            r_err   <= ~w_legal;
         end
         if (r_state == StExec) begin
            r_data <= r_err ? '0 : i_alu_res;
         end
      end
   end

   always_comb begin
      w_state_nxt      = r_state;
      io_bus.req_ready = 2'b00;
      io_bus.rsp_valid = 2'b00;
      unique case (r_state)
         StIdle: begin
            if (w_accept) begin
               io_bus.req_ready = w_gnt & {2{i_rst_n}};
               w_state_nxt      = StExec;
            end
         end
         StExec: begin
            w_state_nxt = StResp;
         end
         StResp: begin
            io_bus.rsp_valid = r_owner ? 2'b10 : 2'b01;
            if (io_bus.rsp_ready[r_owner]) begin
               w_state_nxt = StIdle;
            end
         end
         default: begin
            w_state_nxt = StIdle;
         end
      endcase
   end

   assign io_bus.rsp_data = r_data;
   assign io_bus.rsp_err  = r_err;
   assign o_alu_a         = r_a;
   assign o_alu_b         = r_b;
   assign o_alu_op        = r_op;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed self-checking bench for alu_share_arbiter; models the combinational ALU locally.
module tb_alu_share_arbiter;

   logic        clk;
   logic        rst_n;
   logic [31:0] w_alu_a, w_alu_b, w_alu_res;
   logic [3:0]  w_alu_op;
   int          n_vec  = 0;
   int          n_miss = 0;

   alu_share_arbiter_if #(.WIDTH(32), .OP_W(4)) u_bus ();

   alu_share_arbiter #(.WIDTH(32), .OP_W(4)) u_dut (
      .i_clk     (clk),
      .i_rst_n   (rst_n),
      .io_bus    (u_bus.slave),
      .o_alu_a   (w_alu_a),
      .o_alu_b   (w_alu_b),
      .o_alu_op  (w_alu_op),
      .i_alu_res (w_alu_res)
   );

   function automatic logic [31:0] alu_model(input logic [3:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
      case (op)
         4'b0000: return a + b;
         4'b1000: return a - b;
         4'b0001: return a << b[4:0];
         4'b0010: return {31'd0, $signed(a) < $signed(b)};
         4'b0011: return {31'd0, a < b};
         4'b0100: return a ^ b;
         4'b0101: return a >> b[4:0];
         4'b1101: return $unsigned($signed(a) >>> b[4:0]);
         4'b0110: return a | b;
         4'b0111: return a & b;
         4'b1001: return b;
         default: return 32'd0;
      endcase
   endfunction

   always_comb w_alu_res = alu_model(w_alu_op, w_alu_a, w_alu_b);

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: sim time limit reached, required $finish earlier");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_miss++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_zero_outputs(input string tag);
      check({tag, "_req_ready"}, 32'(u_bus.req_ready), 32'd0);
      check({tag, "_rsp_valid"}, 32'(u_bus.rsp_valid), 32'd0);
      check({tag, "_rsp_data"},  u_bus.rsp_data,       32'd0);
      check({tag, "_rsp_err"},   32'(u_bus.rsp_err),   32'd0);
      check({tag, "_alu_a"},     w_alu_a,              32'd0);
      check({tag, "_alu_b"},     w_alu_b,              32'd0);
      check({tag, "_alu_op"},    32'(w_alu_op),        32'd0);
   endtask

   // Single transaction from requester r with rsp_ready held high.
   task automatic run_op(input string tag, input int r, input logic [3:0] op,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_d, input logic exp_e);
      int cnt;
      if (r == 0) begin
         u_bus.req_op0 = op; u_bus.req_a0 = a; u_bus.req_b0 = b;
         u_bus.req_valid = 2'b01;
      end else begin
         u_bus.req_op1 = op; u_bus.req_a1 = a; u_bus.req_b1 = b;
         u_bus.req_valid = 2'b10;
      end
      u_bus.rsp_ready = 2'b11;
      #1;
      cnt = 0;
      while (u_bus.req_ready == 2'b00 && cnt < 8) begin
         tick();
         #1;
         cnt++;
      end
      check({tag, "_accept"}, 32'(u_bus.req_ready), (r == 0) ? 32'd1 : 32'd2);
      tick();
      u_bus.req_valid = 2'b00;
      #1;
      check({tag, "_exec_valid"}, 32'(u_bus.rsp_valid), 32'd0);
      check({tag, "_alu_op"},     32'(w_alu_op), exp_e ? 32'd0 : 32'(op));
      check({tag, "_alu_a"},      w_alu_a,       exp_e ? 32'd0 : a);
      tick();
      #1;
      check({tag, "_rsp_valid"}, 32'(u_bus.rsp_valid), (r == 0) ? 32'd1 : 32'd2);
      check({tag, "_rsp_data"},  u_bus.rsp_data, exp_d);
      check({tag, "_rsp_err"},   32'(u_bus.rsp_err), 32'(exp_e));
      tick();
   endtask

   initial begin
      int exp_g[4];
      int grants[$];
      int seen;

      rst_n           = 1'b0;
      u_bus.req_valid = 2'b00;
      u_bus.rsp_ready = 2'b00;
      u_bus.req_op0   = 4'd0; u_bus.req_a0 = 32'd0; u_bus.req_b0 = 32'd0;
      u_bus.req_op1   = 4'd0; u_bus.req_a1 = 32'd0; u_bus.req_b1 = 32'd0;
      repeat (3) @(posedge clk);
      #1;
      check_zero_outputs("reset");
      rst_n = 1'b1;
      tick();

      run_op("add_r0", 0, 4'b0000, 32'd5, 32'd7, 32'd12, 1'b0);
      run_op("illegal_r1", 1, 4'b1010, 32'd1, 32'd1, 32'd0, 1'b1);

      // Both requesters valid every cycle for four transactions.
      u_bus.req_op0 = 4'b1000; u_bus.req_a0 = 32'd10;         u_bus.req_b0 = 32'd3;
      u_bus.req_op1 = 4'b1101; u_bus.req_a1 = 32'hFFFF_FFF0;  u_bus.req_b1 = 32'd2;
      u_bus.req_valid = 2'b11;
      u_bus.rsp_ready = 2'b11;
      for (int c = 0; c < 12; c++) begin
         #1;
         if (u_bus.req_ready == 2'b01) grants.push_back(0);
         if (u_bus.req_ready == 2'b10) grants.push_back(1);
         if (u_bus.rsp_valid == 2'b01) check("both_r0_data", u_bus.rsp_data, 32'd7);
         if (u_bus.rsp_valid == 2'b10) check("both_r1_data", u_bus.rsp_data, 32'hFFFF_FFFC);
         tick();
      end
      u_bus.req_valid = 2'b00;
`ifdef ALU_ARB_RR_EN
      exp_g = '{0, 1, 0, 1};
`else
      exp_g = '{0, 0, 0, 0};
`endif
      check("both_grant_count", 32'(grants.size()), 32'd4);
      for (int g = 0; g < 4; g++) begin
         check($sformatf("both_grant%0d", g), (g < grants.size()) ? 32'(grants[g]) : 32'hFFFF,
               32'(exp_g[g]));
      end

      // Backpressure: R0 SLTU held in RESP while R1 waits.
      u_bus.req_op0 = 4'b0011; u_bus.req_a0 = 32'hFFFF_FFFF; u_bus.req_b0 = 32'd1;
      u_bus.req_valid = 2'b01;
      u_bus.rsp_ready = 2'b00;
      #1;
      check("bp_accept_r0", 32'(u_bus.req_ready), 32'd1);
      tick();
      u_bus.req_op1 = 4'b0100; u_bus.req_a1 = 32'd6; u_bus.req_b1 = 32'd3;
      u_bus.req_valid = 2'b10;
      #1;
      check("bp_exec_ready", 32'(u_bus.req_ready), 32'd0);
      tick();
      u_bus.rsp_ready = 2'b10;
      for (int i = 0; i < 4; i++) begin
         #1;
         check($sformatf("bp_hold_valid%0d", i), 32'(u_bus.rsp_valid), 32'd1);
         check($sformatf("bp_hold_data%0d", i),  u_bus.rsp_data, 32'd0);
         check($sformatf("bp_hold_ready%0d", i), 32'(u_bus.req_ready), 32'd0);
         tick();
      end
      u_bus.rsp_ready = 2'b01;
      #1;
      check("bp_release_valid", 32'(u_bus.rsp_valid), 32'd1);
      tick();
      #1;
      check("bp_r1_accept", 32'(u_bus.req_ready), 32'd2);
      tick();
      u_bus.req_valid = 2'b00;
      tick();
      #1;
      check("bp_r1_valid", 32'(u_bus.rsp_valid), 32'd2);
      check("bp_r1_data",  u_bus.rsp_data, 32'd5);
      u_bus.rsp_ready = 2'b11;
      tick();

      // Asynchronous reset in EXEC drops the in-flight op.
      u_bus.req_op0 = 4'b0000; u_bus.req_a0 = 32'd3; u_bus.req_b0 = 32'd4;
      u_bus.req_valid = 2'b01;
      tick();
      u_bus.req_valid = 2'b00;
      #1;
      check("rst_pre_alu_a", w_alu_a, 32'd3);
      #1;
      rst_n = 1'b0;
      #1;
      check_zero_outputs("rst_mid");
      tick();
      rst_n = 1'b1;
      seen = 0;
      for (int i = 0; i < 4; i++) begin
         #1;
         if (u_bus.rsp_valid != 2'b00) seen++;
         tick();
      end
      check("rst_no_rsp", 32'(seen), 32'd0);
      run_op("sll_r0", 0, 4'b0001, 32'd1, 32'd4, 32'd16, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
